apb_master_bridge: RTL and testbench

Single-outstanding APB master that converts a valid/ready request stream into APB SETUP/ACCESS transfers and returns read data and error status on a valid/ready response stream. Sits directly upstream of the APB peripheral register file, driving its psel/penable/paddr/pwdata/pwrite and consuming its prdata/pready/pslverr. One transfer in flight at a time; no pipelining across transfers.

---
 rtl/apb_master_bridge.sv | 184 ++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Single-outstanding APB master. A valid/ready request is turned into one
//   APB SETUP + ACCESS transfer. The result (read data, slave error) is then
//   held on a valid/ready response channel until it is consumed. Only after
//   that is the next request taken.
//
//   Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
//   that sees no pready within TIMEOUT_CYCLES cycles. An aborted transfer
//   responds with rsp_err=1 and rsp_rdata=0. Without the macro, ACCESS waits
//   for pready indefinitely.
//
//   psel/penable/rsp_valid are decoded from the registered state only, so
//   there is no combinational path from the APB inputs to the APB outputs.
`timescale 1ns/1ps

module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              prst,
  // request stream
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_write,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB master side
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // A zero timeout would make the abort compare wrap; reject it at elaboration.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  logic                w_req_ready;
  logic                w_psel;
  logic                w_penable;
  logic                w_rsp_valid;
  logic                w_req_hs;
  logic                w_access_done;
  logic                w_abort;

  // Handshakes and completion qualifiers. pready only counts in ACCESS.
  assign w_req_hs      = req_valid & w_req_ready;
  assign w_access_done = (r_state == ST_ACCESS) & pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]    r_tmo_cnt;

  // ACCESS wait counter: zero outside ACCESS, counts edges with pready low.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_tmo_cnt <= '0;
    end else if (r_state != ST_ACCESS) begin
      r_tmo_cnt <= '0;
    end else if (!pready) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // The last permitted wait edge aborts unless pready arrives on it.
  assign w_abort = (r_state == ST_ACCESS) & ~pready &
                   (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded channel outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = ~prst;
        if (req_valid && !prst) begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_psel      = 1'b1;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (pready || w_abort) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // APB address/data/direction: loaded on request accept, held otherwise.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else if (w_req_hs) begin
      r_paddr  <= req_addr;
      r_pwdata <= req_wdata;
      r_pwrite <= req_write;
    end
  end

  // Response capture: on completion, or forced error on abort.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_access_done) begin
      r_rsp_err   <= pslverr;
      r_rsp_rdata <= r_pwrite ? '0 : prdata;
    end else if (w_abort) begin
      r_rsp_err   <= 1'b1;
      r_rsp_rdata <= '0;
    end
  end

  assign req_ready = w_req_ready;
  assign psel      = w_psel;
  assign penable   = w_penable;
  assign rsp_valid = w_rsp_valid;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pwrite    = r_pwrite;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge. A behavioural APB slave inserts
//   a chosen number of wait states. A transfer-level model predicts penable and
//   psel lengths, response latency, read data and error for each transfer.
//   Build with APB_MASTER_TIMEOUT_EN to also cover the ACCESS timeout.
`timescale 1ns/1ps

module tb_apb_master_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          pclk = 1'b0;
  logic          prst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_write;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int checks = 0;
  int errors = 0;

  // observations of the last transfer
  int            obs_psel;
  int            obs_pen;
  int            obs_lat;
  logic [DW-1:0] obs_rdata;
  logic          obs_err;
  bit            obs_addr_ok;
  bit            obs_resp_ok;
  bit            obs_post_ok;
  bit            obs_tmo;

  apb_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel),
    .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // ---------------- reference model (transfer level) ----------------
  function automatic bit m_abort(int waits);
`ifdef APB_MASTER_TIMEOUT_EN
    return (waits >= TMO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_pen(int waits);
    return m_abort(waits) ? TMO : waits + 1;
  endfunction

  function automatic logic [DW-1:0] m_rdata(bit wr, int waits, logic [DW-1:0] prd);
    return (wr || m_abort(waits)) ? '0 : prd;
  endfunction

  function automatic logic m_err(int waits, logic slv);
    return m_abort(waits) ? 1'b1 : slv;
  endfunction

  // ---------------- transfer driver (observes, does not judge) -------
  task automatic run_xfer(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input bit wr, input int waits, input logic [DW-1:0] prd,
                          input logic slv, input int rsp_delay, input bit hold_req);
    int n, edges, delay;
    bit seen, hs_pending, done;
    obs_psel = 0; obs_pen = 0; obs_lat = -1; obs_rdata = 'x; obs_err = 1'bx;
    obs_addr_ok = 1; obs_resp_ok = 1; obs_post_ok = 0; obs_tmo = 0;
    req_addr = addr; req_wdata = wdata; req_write = wr; req_valid = 1'b1;
    rsp_ready = 1'b0; pready = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge pclk); n++; end
    if (req_ready !== 1'b1) begin obs_tmo = 1; req_valid = 1'b0; return; end
    @(negedge pclk);
    edges = 1;
    if (!hold_req) req_valid = 1'b0;
    seen = 0; hs_pending = 0; done = 0; delay = rsp_delay;
    for (int c = 0; c < 300 && !done; c++) begin
      if (hs_pending) begin
        obs_post_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
        done = 1;
      end else begin
        if (psel === 1'b1) begin
          obs_psel++;
          if (paddr !== addr || pwdata !== wdata || pwrite !== wr) obs_addr_ok = 0;
        end
        if (req_ready === 1'b1) obs_resp_ok = 0;
        if (penable === 1'b1) begin
          pready  = (obs_pen == waits);
          prdata  = (obs_pen == waits) ? prd : DW'($urandom);
          pslverr = (obs_pen == waits) ? slv : 1'b1;
          obs_pen++;
        end else begin
          pready = 1'b0; pslverr = 1'b1; prdata = DW'($urandom);
        end
        if (rsp_valid === 1'b1) begin
          if (!seen) begin
            seen = 1; obs_lat = edges; obs_rdata = rsp_rdata; obs_err = rsp_err;
          end else if (rsp_rdata !== obs_rdata || rsp_err !== obs_err) begin
            obs_resp_ok = 0;
          end
          if (psel !== 1'b0) obs_resp_ok = 0;
          if (delay == 0) begin rsp_ready = 1'b1; hs_pending = 1; end
          else delay--;
        end
        @(negedge pclk);
        edges++;
      end
    end
    if (!done) obs_tmo = 1;
    rsp_ready = 1'b0; pready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    prst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0; req_wdata = '0;
    req_write = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid, psel, penable, pwrite, rsp_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000000", {req_ready, rsp_valid, psel, penable, pwrite, rsp_err});
    end
    checks++; if (paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h exp 0", paddr, pwdata, rsp_rdata);
    end
    repeat (2) @(negedge pclk);
    prst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_write();
    run_xfer(32'h10, 32'hDEADBEEF, 1'b1, 0, 32'hA5A5A5A5, 1'b0, 0, 1'b0);
    checks++; if (obs_tmo) begin errors++; $display("FAIL write_bound expired"); end
    checks++; if (obs_psel !== 2 || obs_pen !== 1) begin
      errors++; $display("FAIL write_psel_pen got %0d/%0d exp 2/1", obs_psel, obs_pen);
    end
    checks++; if (obs_lat !== 3) begin errors++; $display("FAIL write_latency got %0d exp 3", obs_lat); end
    checks++; if (!obs_addr_ok) begin errors++; $display("FAIL write_apb_fields got 0 exp 1"); end
    checks++; if (obs_rdata !== '0 || obs_err !== 1'b0) begin
      errors++; $display("FAIL write_rsp got %h/%b exp 0/0", obs_rdata, obs_err);
    end
    checks++; if (!obs_post_ok) begin errors++; $display("FAIL write_post_hs got 0 exp 1"); end
  endtask

  task automatic test_read_wait();
    run_xfer(32'h40, 32'h0, 1'b0, 3, 32'h12345678, 1'b0, 0, 1'b0);
    checks++; if (obs_pen !== 4 || obs_psel !== 5) begin
      errors++; $display("FAIL read_wait_pen got %0d/%0d exp 4/5", obs_pen, obs_psel);
    end
    checks++; if (obs_lat !== 6) begin errors++; $display("FAIL read_wait_lat got %0d exp 6", obs_lat); end
    checks++; if (!obs_addr_ok) begin errors++; $display("FAIL read_wait_stable got 0 exp 1"); end
    checks++; if (obs_rdata !== 32'h12345678 || obs_err !== 1'b0) begin
      errors++; $display("FAIL read_wait_rsp got %h/%b exp 12345678/0", obs_rdata, obs_err);
    end
  endtask

  task automatic test_slverr();
    run_xfer(32'h44, 32'h0, 1'b0, 2, 32'hCAFE0001, 1'b1, 0, 1'b0);
    checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'hCAFE0001) begin
      errors++; $display("FAIL slverr_rsp got %h/%b exp cafe0001/1", obs_rdata, obs_err);
    end
    checks++; if (obs_pen !== 3) begin errors++; $display("FAIL slverr_pen got %0d exp 3", obs_pen); end
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h80, 32'h11112222, 1'b0, 1, 32'h55667788, 1'b0, 5, 1'b1);
    checks++; if (!obs_resp_ok) begin errors++; $display("FAIL backpressure_hold got 0 exp 1"); end
    checks++; if (obs_rdata !== 32'h55667788 || obs_err !== 1'b0) begin
      errors++; $display("FAIL backpressure_rsp got %h/%b exp 55667788/0", obs_rdata, obs_err);
    end
    checks++; if (!obs_post_ok) begin errors++; $display("FAIL backpressure_post got 0 exp 1"); end
    run_xfer(32'h84, 32'h33334444, 1'b1, 0, 32'h0, 1'b0, 0, 1'b0);
    checks++; if (obs_lat !== 3 || !obs_addr_ok || obs_err !== 1'b0) begin
      errors++; $display("FAIL back_to_back_next got lat %0d ok %0d err %b exp 3 1 0", obs_lat, obs_addr_ok, obs_err);
    end
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    run_xfer(32'hC0, 32'h0, 1'b0, 1000, 32'hFFFF0000, 1'b0, 0, 1'b0);
    checks++; if (obs_pen !== TMO || obs_lat !== TMO + 2) begin
      errors++; $display("FAIL timeout_pen got %0d/%0d exp %0d/%0d", obs_pen, obs_lat, TMO, TMO + 2);
    end
    checks++; if (obs_err !== 1'b1 || obs_rdata !== '0) begin
      errors++; $display("FAIL timeout_rsp got %h/%b exp 0/1", obs_rdata, obs_err);
    end
    run_xfer(32'hC4, 32'h0, 1'b0, TMO - 1, 32'h0BADF00D, 1'b0, 0, 1'b0);
    checks++; if (obs_pen !== TMO || obs_err !== 1'b0 || obs_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL timeout_edge_ready got %0d/%b/%h exp %0d/0/0badf00d", obs_pen, obs_err, obs_rdata, TMO);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit quiet;
    req_addr = 32'h99; req_wdata = 32'h77; req_write = 1'b1; req_valid = 1'b1;
    pready = 1'b0;
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rstmid_in_access got %b exp 1", penable); end
    #2 prst = 1'b1; pready = 1'b1;
    #1;
    checks++; if ({psel, penable, rsp_valid, req_ready} !== 4'b0 || paddr !== '0) begin
      errors++; $display("FAIL rstmid_async got %b paddr %h exp 0000 0", {psel, penable, rsp_valid, req_ready}, paddr);
    end
    @(negedge pclk);
    prst = 1'b0; pready = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", req_ready); end
    quiet = 1;
    repeat (6) begin
      @(negedge pclk);
      if (rsp_valid !== 1'b0 || psel !== 1'b0) quiet = 0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL rstmid_no_rsp got 0 exp 1"); end
    run_xfer(32'h9C, 32'h600DCAFE, 1'b1, 1, 32'h0, 1'b0, 0, 1'b0);
    checks++; if (obs_lat !== 4 || !obs_addr_ok || obs_err !== 1'b0 || obs_rdata !== '0) begin
      errors++; $display("FAIL rstmid_next got lat %0d ok %0d %b/%h exp 4 1 0/0", obs_lat, obs_addr_ok, obs_err, obs_rdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] wd, prd;
      bit wr;
      logic slv;
      int waits, dly;
      a = AW'($urandom); wd = DW'($urandom); prd = DW'($urandom);
      wr = 1'($urandom); slv = 1'($urandom_range(0, 3) == 0);
`ifdef APB_MASTER_TIMEOUT_EN
      waits = $urandom_range(0, 20);
`else
      waits = $urandom_range(0, 6);
`endif
      dly = $urandom_range(0, 3);
      run_xfer(a, wd, wr, waits, prd, slv, dly, 1'b0);
      checks++; if (obs_tmo) begin errors++; $display("FAIL rand%0d_bound expired", i); end
      checks++; if (obs_pen !== m_pen(waits) || obs_psel !== m_pen(waits) + 1 || obs_lat !== m_pen(waits) + 2) begin
        errors++; $display("FAIL rand%0d_timing got %0d/%0d/%0d exp %0d/%0d/%0d", i, obs_pen, obs_psel, obs_lat,
                           m_pen(waits), m_pen(waits) + 1, m_pen(waits) + 2);
      end
      checks++; if (obs_rdata !== m_rdata(wr, waits, prd) || obs_err !== m_err(waits, slv)) begin
        errors++; $display("FAIL rand%0d_rsp got %h/%b exp %h/%b", i, obs_rdata, obs_err,
                           m_rdata(wr, waits, prd), m_err(waits, slv));
      end
      checks++; if (!obs_addr_ok || !obs_resp_ok || !obs_post_ok) begin
        errors++; $display("FAIL rand%0d_proto got %0d%0d%0d exp 111", i, obs_addr_ok, obs_resp_ok, obs_post_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
